// File: rtl/immediate_fetch_ctrl_pkg.sv
// Shared types and defaults for the decode-stage immediate sequencer.
// Covers state encoding, extension mode codes and width defaults.
package immediate_fetch_ctrl_pkg;

    localparam int INSTR_WIDTH_DEF = 16;
    localparam int DATA_WIDTH_DEF  = 32;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_IMM = 1'b1
    } state_t;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_t;

endpackage

// File: rtl/immediate_fetch_ctrl_if.sv
// Fetch/decode handshake bundle around the immediate sequencer.
// The master side drives fetch words and decode readiness.
interface immediate_fetch_ctrl_if #(
    parameter int INSTR_WIDTH = 16,
    parameter int DATA_WIDTH  = 32
);
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr_word;
    logic                   needs_imm;
    logic                   sign_ext;
    logic                   flush;
    logic                   down_ready;
    logic                   stall_out;
    logic                   imm_pending;
    logic                   instr_out_valid;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic                   imm_valid;
    logic [DATA_WIDTH-1:0]  imm_data;

    modport master (
        output instr_valid, instr_word, needs_imm, sign_ext,
        output flush, down_ready,
        input  stall_out, imm_pending, instr_out_valid,
        input  instr_out, imm_valid, imm_data
    );

    modport slave (
        input  instr_valid, instr_word, needs_imm, sign_ext,
        input  flush, down_ready,
        output stall_out, imm_pending, instr_out_valid,
        output instr_out, imm_valid, imm_data
    );
endinterface

// File: rtl/immediate_fetch_ctrl_imm_extend.sv
// Combinational zero/sign extension of an immediate word.
module immediate_fetch_ctrl_imm_extend #(
    parameter int INSTR_WIDTH = 16,
    parameter int DATA_WIDTH  = 32
) (
    input  logic [INSTR_WIDTH-1:0] input_data,
    input  logic                   sign_ext,
    output logic [DATA_WIDTH-1:0]  output_data
);
    localparam int PAD = DATA_WIDTH - INSTR_WIDTH;

    generate
        if (PAD == 0) begin : g_none
            assign output_data = input_data;
        end else begin : g_pad
            logic fill;
            assign fill = sign_ext & input_data[INSTR_WIDTH-1];
            assign output_data = {{PAD{fill}}, input_data};
        end
    endgenerate
endmodule

// File: rtl/immediate_fetch_ctrl.sv
// Decode-stage sequencer pairing opcodes with a trailing immediate word
// and presenting both to decode as one registered transaction.
module immediate_fetch_ctrl
    import immediate_fetch_ctrl_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input logic clk,
    input logic rst,
    immediate_fetch_ctrl_if.slave bus
);
    state_t                 state;
    state_t                 state_nxt;
    logic [INSTR_WIDTH-1:0] op_q;
    ext_t                   ext_q;

    logic                   out_valid_q;
    logic [INSTR_WIDTH-1:0] out_instr_q;
    logic                   out_immv_q;
    logic [DATA_WIDTH-1:0]  out_data_q;

    logic                   accept;
    logic                   consume;
    logic                   load_plain;
    logic                   load_imm;
    logic                   capture;
    logic [DATA_WIDTH-1:0]  ext_data;

    // A flushed word never counts as consumed.
    assign accept     = !(out_valid_q && !bus.down_ready);
    assign consume    = bus.instr_valid && accept && !bus.flush;
    assign load_plain = consume && (state == IDLE) && !bus.needs_imm;
    assign capture    = consume && (state == IDLE) && bus.needs_imm;
    assign load_imm   = consume && (state == WAIT_IMM);

    immediate_fetch_ctrl_imm_extend #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_imm_extend (
        .input_data  (bus.instr_word),
        .sign_ext    (ext_q == EXT_SIGN),
        .output_data (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (capture)  state_nxt = WAIT_IMM;
            WAIT_IMM: if (load_imm) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            op_q  <= '0;
            ext_q <= EXT_ZERO;
        end else if (capture) begin
            op_q  <= bus.instr_word;
            ext_q <= ext_t'(bus.sign_ext);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_immv_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            out_immv_q  <= 1'b0;
        end else if (accept) begin
            if (load_plain) begin
                out_valid_q <= 1'b1;
                out_instr_q <= bus.instr_word;
                out_immv_q  <= 1'b0;
                out_data_q  <= '0;
            end else if (load_imm) begin
                out_valid_q <= 1'b1;
                out_instr_q <= op_q;
                out_immv_q  <= 1'b1;
                out_data_q  <= ext_data;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.stall_out       = out_valid_q && !bus.down_ready;
        bus.imm_pending     = (state == WAIT_IMM);
        bus.instr_out_valid = out_valid_q;
        bus.instr_out       = out_instr_q;
        bus.imm_valid       = out_immv_q;
        bus.imm_data        = out_data_q;
    end
endmodule
